// File: rtl/stopwatch_pkg.sv
// Shared state encoding, default timing constants and counter-width helper
// for the stopwatch front-end control stage.
package stopwatch_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } sw_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_TICK_DIV        = 5000000;

    // Bits needed to hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button and strobe bundle between the stopwatch front end and its neighbours.
// LAP/HOLD exist only when STOPWATCH_LAP_EN is defined.
interface stopwatch_ctrl_if;
    logic STRTSTOP;
    logic CLEAR;
    logic RUN;
    logic TENTH_TICK;
    logic CLR_OUT;
`ifdef STOPWATCH_LAP_EN
    logic LAP;
    logic HOLD;

    modport master (output STRTSTOP, CLEAR, LAP, input RUN, TENTH_TICK, CLR_OUT, HOLD);
    modport slave  (input STRTSTOP, CLEAR, LAP, output RUN, TENTH_TICK, CLR_OUT, HOLD);
`else
    modport master (output STRTSTOP, CLEAR, input RUN, TENTH_TICK, CLR_OUT);
    modport slave  (input STRTSTOP, CLEAR, output RUN, TENTH_TICK, CLR_OUT);
`endif
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One push-button channel: synchroniser, stable-level debounce counter and
// a one-cycle press pulse on each accepted 1 -> 0 transition.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);
    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   level_d1_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            cnt_q      <= '0;
            level_q    <= 1'b1;
            level_d1_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            level_d1_q <= level_q;
            if (sync_lvl == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_lvl;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Release edges are deliberately not reported.
    assign press = level_d1_q & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounced start/stop toggle, tenth-second tick divider
// and counter clear. Optional lap/hold logic under STOPWATCH_LAP_EN.
//
// state   | meaning
// STOPPED | divider frozen, clear presses accepted
// RUNNING | divider counting, tick emitted every TICK_DIV cycles
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEF_TICK_DIV
) (
    input logic             CLK,
    input logic             RESET,
    stopwatch_ctrl_if.slave bus
);
    localparam int            DW       = cnt_width(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    sw_state_t     state_q, state_d;
    logic          start_press, clear_press;
    logic [DW-1:0] div_q, div_d;
    logic          run_q, tick_q, clr_q;
    logic          tick_d, clr_d;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(CLK), .rst_n(RESET), .btn_raw(bus.STRTSTOP), .press(start_press)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk(CLK), .rst_n(RESET), .btn_raw(bus.CLEAR), .press(clear_press)
    );

`ifdef STOPWATCH_LAP_EN
    logic lap_press, hold_q, hold_d;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk(CLK), .rst_n(RESET), .btn_raw(bus.LAP), .press(lap_press)
    );
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= STOPPED;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_press) state_d = (state_q == STOPPED) ? RUNNING : STOPPED;
    end

    // The stop cycle does not advance the divider, so a resume continues
    // from exactly the count reached while running.
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        clr_d  = 1'b0;
        if (state_q == RUNNING) begin
            if (!start_press) begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
        end else if (clear_press && !start_press) begin
            clr_d = 1'b1;
            div_d = '0;
        end
`ifdef STOPWATCH_LAP_EN
        hold_d = hold_q;
        if (state_d == STOPPED || clr_d) hold_d = 1'b0;
        else if (lap_press && state_q == RUNNING) hold_d = ~hold_q;
`endif
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_q  <= '0;
            run_q  <= 1'b0;
            tick_q <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            run_q  <= (state_d == RUNNING);
            tick_q <= tick_d;
            clr_q  <= clr_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) hold_q <= 1'b0;
        else        hold_q <= hold_d;
    end

    assign bus.HOLD = hold_q;
`endif

    assign bus.RUN        = run_q;
    assign bus.TENTH_TICK = tick_q;
    assign bus.CLR_OUT    = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a history-window reference model.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int TD   = 10;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .TICK_DIV(TD)) dut (
        .CLK(CLK), .RESET(RESET), .bus(sw_if)
    );

    always #5 CLK = ~CLK;

`ifdef STOPWATCH_LAP_EN
    initial sw_if.LAP = 1'b1;
`endif

    // Reference model: a button's debounced level flips once the last DEB
    // synchronised samples (raw samples SYNC edges old) all disagree with it.
    bit hs[$], hc[$];
    bit m_deb_s, m_deb_c, m_fall_s, m_fall_c, m_run, m_tick, m_clr;
    int m_div, m_cnt_s, m_r;

    function automatic int mis_run(input bit q[$], input bit deb);
        int r;
        r = 0;
        for (int i = q.size() - SYNC; i >= 0; i--) begin
            if (q[i] == deb) break;
            r++;
        end
        return r;
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hs.delete();
            hc.delete();
            for (int i = 0; i < SYNC + DEB; i++) begin
                hs.push_back(1'b1);
                hc.push_back(1'b1);
            end
            m_deb_s = 1; m_deb_c = 1; m_fall_s = 0; m_fall_c = 0;
            m_run = 0; m_tick = 0; m_clr = 0; m_div = 0; m_cnt_s = 0;
        end else begin
            m_tick = 0;
            m_clr  = 0;
            if (m_run && !m_fall_s) begin
                m_div  = (m_div + 1) % TD;
                m_tick = (m_div == 0);
            end else if (!m_run && !m_fall_s && m_fall_c) begin
                m_clr = 1;
                m_div = 0;
            end
            if (m_fall_s) m_run = !m_run;

            m_r = mis_run(hs, m_deb_s);
            m_fall_s = 0;
            if (m_r >= DEB) begin
                m_deb_s  = !m_deb_s;
                m_fall_s = !m_deb_s;
                m_r      = 0;
            end
            m_cnt_s = m_r;
            hs.push_back(sw_if.STRTSTOP);
            if (hs.size() > 40) void'(hs.pop_front());

            m_r = mis_run(hc, m_deb_c);
            m_fall_c = 0;
            if (m_r >= DEB) begin
                m_deb_c  = !m_deb_c;
                m_fall_c = !m_deb_c;
            end
            hc.push_back(sw_if.CLEAR);
            if (hc.size() > 40) void'(hc.pop_front());
        end
    end

    task automatic test_reset();
        RESET = 0; sw_if.STRTSTOP = 0; sw_if.CLEAR = 0;
        repeat (5) begin
            @(negedge CLK); n_chk++;
            if ({sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold: run/tick/clr=%b expected 000", {sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT});
            end
        end
        sw_if.STRTSTOP = 1; sw_if.CLEAR = 1; RESET = 1;
        repeat (12) begin
            @(negedge CLK); n_chk++;
            if ({sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_release: run/tick/clr=%b expected 000", {sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT});
            end
        end
    endtask

    task automatic test_bounce();
        bit pat[$];
        pat = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        foreach (pat[i]) begin
            sw_if.STRTSTOP = pat[i];
            @(negedge CLK);
            n_chk++;
            if (int'(dut.u_db_start.cnt_q) != m_cnt_s) begin
                n_fail++;
                $display("FAIL bounce_cnt: step %0d cnt=%0d expected %0d", i, dut.u_db_start.cnt_q, m_cnt_s);
            end
            n_chk++;
            if (sw_if.RUN !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_run: step %0d run=%b expected 0", i, sw_if.RUN);
            end
        end
    endtask

    task automatic test_start();
        int edges, ticks;
        edges = 0; ticks = 0;
        sw_if.STRTSTOP = 0;
        while (sw_if.RUN !== 1'b1 && edges < 20) begin
            @(negedge CLK); edges++;
        end
        n_chk++;
        if (edges != SYNC + DEB + 1) begin
            n_fail++;
            $display("FAIL start_latency: run rose after %0d edges expected %0d", edges, SYNC + DEB + 1);
        end
        repeat (50) begin
            @(negedge CLK);
            if (sw_if.TENTH_TICK === 1'b1) ticks++;
            n_chk++;
            if ({sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT} !== {1'b1, m_tick, 1'b0}) begin
                n_fail++;
                $display("FAIL start_hold: run/tick/clr=%b expected %b", {sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT}, {1'b1, m_tick, 1'b0});
            end
        end
        n_chk++;
        if (ticks != 5) begin
            n_fail++;
            $display("FAIL start_ticks: %0d ticks in 50 cycles expected 5", ticks);
        end
        sw_if.STRTSTOP = 1;
        repeat (10) begin
            @(negedge CLK); n_chk++;
            if ({sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT} !== {m_run, m_tick, m_clr}) begin
                n_fail++;
                $display("FAIL start_release: run/tick/clr=%b expected %b", {sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT}, {m_run, m_tick, m_clr});
            end
        end
    endtask

    task automatic test_stop_resume();
        int guard, n;
        guard = 0;
        while (m_div != 0 && guard < 20) begin
            @(negedge CLK); guard++;
        end
        n_chk++;
        if (int'(dut.div_q) != 0) begin
            n_fail++;
            $display("FAIL stop_align: div=%0d expected 0", dut.div_q);
        end
        sw_if.STRTSTOP = 0;
        n = 0;
        while (sw_if.RUN !== 1'b0 && n < 20) begin
            @(negedge CLK); n++;
        end
        n_chk++;
        if (n != SYNC + DEB + 1) begin
            n_fail++;
            $display("FAIL stop_latency: run fell after %0d edges expected %0d", n, SYNC + DEB + 1);
        end
        n_chk++;
        if (int'(dut.div_q) != 6) begin
            n_fail++;
            $display("FAIL stop_count: div=%0d expected 6", dut.div_q);
        end
        sw_if.STRTSTOP = 1;
        repeat (20) begin
            @(negedge CLK); n_chk++;
            if ({sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT} !== 3'b000) begin
                n_fail++;
                $display("FAIL stopped_idle: run/tick/clr=%b expected 000", {sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT});
            end
        end
        sw_if.STRTSTOP = 0;
        n = 0;
        while (sw_if.RUN !== 1'b1 && n < 20) begin
            @(negedge CLK); n++;
        end
        n = 0;
        while (sw_if.TENTH_TICK !== 1'b1 && n < 20) begin
            @(negedge CLK); n++;
        end
        n_chk++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL resume_tick: first tick %0d cycles after restart expected 4", n);
        end
        sw_if.STRTSTOP = 1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_clear();
        int n, pulses;
        sw_if.CLEAR = 0;
        repeat (12) begin
            @(negedge CLK); n_chk++;
            if ({sw_if.RUN, sw_if.CLR_OUT} !== 2'b10) begin
                n_fail++;
                $display("FAIL clear_running: run/clr=%b expected 10", {sw_if.RUN, sw_if.CLR_OUT});
            end
        end
        sw_if.CLEAR = 1;
        repeat (10) @(negedge CLK);
        sw_if.STRTSTOP = 0;
        n = 0;
        while (sw_if.RUN !== 1'b0 && n < 20) begin
            @(negedge CLK); n++;
        end
        sw_if.STRTSTOP = 1;
        repeat (10) @(negedge CLK);
        sw_if.CLEAR = 0;
        pulses = 0;
        repeat (15) begin
            @(negedge CLK);
            if (sw_if.CLR_OUT === 1'b1) begin
                pulses++;
                n_chk++;
                if (int'(dut.div_q) != 0) begin
                    n_fail++;
                    $display("FAIL clear_div: div=%0d expected 0", dut.div_q);
                end
            end
            n_chk++;
            if ({sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT} !== {m_run, m_tick, m_clr}) begin
                n_fail++;
                $display("FAIL clear_stopped: run/tick/clr=%b expected %b", {sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT}, {m_run, m_tick, m_clr});
            end
        end
        n_chk++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL clear_pulses: %0d clr cycles expected 1", pulses);
        end
        sw_if.CLEAR = 1;
        repeat (10) @(negedge CLK);
        sw_if.STRTSTOP = 0; sw_if.CLEAR = 0;
        repeat (15) begin
            @(negedge CLK); n_chk++;
            if (sw_if.CLR_OUT !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_clr: clr=%b expected 0", sw_if.CLR_OUT);
            end
        end
        n_chk++;
        if (sw_if.RUN !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_run: run=%b expected 1", sw_if.RUN);
        end
        sw_if.STRTSTOP = 1; sw_if.CLEAR = 1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int guard, n;
        guard = 0;
        while (m_div != 7 && guard < 20) begin
            @(negedge CLK); guard++;
        end
        n_chk++;
        if (int'(dut.div_q) != 7 || sw_if.RUN !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_align: div=%0d run=%b expected 7 and 1", dut.div_q, sw_if.RUN);
        end
        #2 RESET = 0;
        #1;
        n_chk++;
        if ({sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_async: run/tick/clr=%b expected 000", {sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT});
        end
        repeat (3) @(negedge CLK);
        RESET = 1;
        repeat (3) @(negedge CLK);
        sw_if.STRTSTOP = 0;
        n = 0;
        while (sw_if.RUN !== 1'b1 && n < 20) begin
            @(negedge CLK); n++;
        end
        n_chk++;
        if (n != SYNC + DEB + 1) begin
            n_fail++;
            $display("FAIL mid_restart: run rose after %0d edges expected %0d", n, SYNC + DEB + 1);
        end
        n = 0;
        while (sw_if.TENTH_TICK !== 1'b1 && n < 30) begin
            @(negedge CLK); n++;
        end
        n_chk++;
        if (n != TD) begin
            n_fail++;
            $display("FAIL mid_first_tick: first tick %0d cycles after start expected %0d", n, TD);
        end
        sw_if.STRTSTOP = 1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 40; seg++) begin
            sw_if.STRTSTOP = ($urandom_range(0, 2) != 0);
            sw_if.CLEAR    = ($urandom_range(0, 2) != 0);
            len = $urandom_range(1, 12);
            repeat (len) begin
                @(negedge CLK); n_chk++;
                if ({sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT} !== {m_run, m_tick, m_clr}) begin
                    n_fail++;
                    $display("FAIL random_outputs: seg %0d run/tick/clr=%b expected %b", seg, {sw_if.RUN, sw_if.TENTH_TICK, sw_if.CLR_OUT}, {m_run, m_tick, m_clr});
                end
                n_chk++;
                if (int'(dut.u_db_start.cnt_q) != m_cnt_s) begin
                    n_fail++;
                    $display("FAIL random_cnt: seg %0d cnt=%0d expected %0d", seg, dut.u_db_start.cnt_q, m_cnt_s);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_start();
        test_stop_resume();
        test_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-end control stage that sits directly upstream of the stopwatch counter/decoder datapath.
- Synchronises and debounces the raw active-low STRTSTOP and CLEAR push buttons.
- Turns each STRTSTOP press into a run/stop toggle.
- Generates the one-cycle tenth-second count-enable tick that the downstream counters consume.
- Issues a one-cycle synchronous clear pulse to the counters.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per button input (minimum 2).
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new button level (minimum 2).
TICK_DIV, 5000000, CLK cycles per tenth-second tick (minimum 2).

Ports:
CLK  input  1  system clock; all state is on its rising edge.
RESET  input  1  asynchronous active-low reset.
STRTSTOP  input  1  raw start/stop button, asynchronous; 1 = released, 0 = pressed.
CLEAR  input  1  raw clear button, asynchronous; 1 = released, 0 = pressed.
RUN  output  1  1 while the stopwatch is running.
TENTH_TICK  output  1  one-cycle pulse, once every TICK_DIV cycles while RUN = 1.
CLR_OUT  output  1  one-cycle synchronous clear for the downstream counters.

Behaviour:
- Reset (RESET = 0, asynchronous):
  - Synchroniser flops and debounced levels go to 1 (released).
  - Debounce counters and the divider counter go to 0.
  - FSM goes to STOPPED.
  - RUN = 0, TENTH_TICK = 0, CLR_OUT = 0.
  - On release, operation resumes at the next CLK edge. A reset asserted mid-operation discards any press in flight.
- Debounce, per button:
  - The synchronised level is compared with the debounced level.
  - On mismatch the counter increments. On match the counter returns to 0.
  - On the DEBOUNCE_CYCLES-th consecutive mismatch cycle, the debounced level takes the synchronised value and the counter returns to 0.
  - A bounce shorter than DEBOUNCE_CYCLES has no effect.
- Press event: a registered falling edge (1 -> 0) of the debounced level. Release events are ignored.
- Latency from raw press (stable low before an edge) to the RUN change: SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges.
- FSM states are STOPPED and RUNNING:
  - STOPPED + start press -> RUNNING.
  - RUNNING + start press -> STOPPED.
  - RUN is a registered decode of RUNNING.
- Divider:
  - Counts 0..TICK_DIV-1 only in RUNNING.
  - TENTH_TICK is registered high for one cycle when the count is TICK_DIV-1; the count then wraps to 0.
  - Stopping freezes the count, and restarting resumes from the frozen value, so no partial tenth is lost.
  - TENTH_TICK is never high while RUN = 0.
- Clear:
  - A clear press in STOPPED gives CLR_OUT = 1 for exactly one cycle (the cycle after the press event) and zeroes the divider count.
  - A clear press in RUNNING is ignored.
- Simultaneous start and clear press events in the same cycle while STOPPED: start wins and clear is discarded.
- A held button produces exactly one press event; no auto-repeat.

Optional Feature:
STOPWATCH_LAP_EN
- Defined:
  - Adds input LAP (raw, active-low) and output HOLD.
  - A debounced LAP press toggles HOLD only while RUNNING. HOLD tells the downstream stage to freeze its display outputs while counting continues.
  - Entering STOPPED, or any CLR_OUT pulse, forces HOLD = 0.
  - HOLD resets to 0.
- Undefined: the LAP and HOLD ports are absent and there is no lap logic.

Decomposition:
- Shared package stopwatch_pkg:
  - FSM state encoding constants (STOPPED = 1'b0, RUNNING = 1'b1).
  - Default DEBOUNCE_CYCLES and TICK_DIV values.
  - Counter-width helper (ceiling log2).
- One sub-module, btn_debounce: synchroniser, debounce counter, debounced level and press pulse.
  - Instantiated for STRTSTOP and CLEAR, and for LAP when STOPWATCH_LAP_EN is defined.
- FSM, divider and clear logic stay in stopwatch_ctrl.

Test Plan:
All scenarios use SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, TICK_DIV = 10.
1. Reset: hold RESET = 0 for 5 cycles with both buttons at 0 -> RUN, TENTH_TICK and CLR_OUT are all 0 during reset. After release with the buttons at 1, no press event occurs.
2. Start: drive STRTSTOP low and hold it -> RUN rises on the 7th edge. TENTH_TICK pulses every 10 cycles, 5 pulses in 50 cycles. Holding the button does not toggle RUN again.
3. Bounce rejection: STRTSTOP low 3 cycles, high 1, low 2, high -> RUN stays 0. Debounce counter checks show it restarting at 0 after each bounce.
4. Stop/resume: stop at divider count 6, wait 20 cycles, restart -> no tick while stopped. The first tick arrives 4 running cycles after RUN returns to 1.
5. Clear:
   - CLEAR press while STOPPED -> single-cycle CLR_OUT and divider reset to 0.
   - CLEAR press while RUNNING -> no CLR_OUT.
   - Start and clear press events in the same cycle -> RUN = 1 and CLR_OUT stays 0.
6. Reset mid-run: assert RESET while RUN = 1 with the divider at 7 -> RUN = 0 immediately (asynchronously). After release the next start gives its first tick a full 10 cycles later.
